// File: rtl/ddr_cache_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ddr_cache_pkg
// Description : Shared types and constants for the DDR3 line cache.
//               Contains the controller state encoding and the line geometry:
//               64-byte lines, 512 bits wide, with a 6-bit byte offset.
// Revision    : 1.0 - initial release
// ============================================================================
package ddr_cache_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ACK  = 2'b01,
        WB   = 2'b10,
        FILL = 2'b11
    } state_e;

    localparam int LINE_BYTES = 64;
    localparam int LINE_BITS  = 512;
    localparam int OFFSET_W   = 6;
    localparam int WORD_SEL_W = 4;

endpackage : ddr_cache_pkg
`default_nettype wire

// File: rtl/ddr_cache_line_merge.sv
`default_nettype none
// ============================================================================
// Module      : ddr_cache_line_merge
// Description : Combinational write merge. Writes the enabled bytes of a
//               32-bit CPU word into one word of a 512-bit cache line and
//               sets the matching bits of the line's dirty byte mask.
//               Byte b of word w is line byte 4w+b.
// Ports       : line_i/dirty_i   current line data and dirty mask
//               word_i           word select within the line (addr[5:2])
//               din_i/sel_i      CPU write data and byte enables
//               line_o/dirty_o   merged line data and updated dirty mask
// Revision    : 1.0 - initial release
// ============================================================================
module ddr_cache_line_merge
    import ddr_cache_pkg::*;
(
    input  logic [LINE_BITS-1:0]  line_i,
    input  logic [LINE_BYTES-1:0] dirty_i,
    input  logic [WORD_SEL_W-1:0] word_i,
    input  logic [31:0]           din_i,
    input  logic [3:0]            sel_i,
    output logic [LINE_BITS-1:0]  line_o,
    output logic [LINE_BYTES-1:0] dirty_o
);

    always_comb begin
        line_o  = line_i;
        dirty_o = dirty_i;
        for (int b = 0; b < 4; b++) begin
            if (sel_i[b]) begin
                line_o[{word_i, 2'(b), 3'b000} +: 8] = din_i[8*b +: 8];
                dirty_o[{word_i, 2'(b)}]             = 1'b1;
            end
        end
    end

endmodule : ddr_cache_line_merge
`default_nettype wire

// File: rtl/ddr_line_cache.sv
`default_nettype none
// ============================================================================
// Module      : ddr_line_cache
// Description : Direct-mapped, write-back, write-allocate cache of 512-bit
//               lines between a 32-bit Wishbone CPU master and the 512-bit
//               Wishbone slave of the DDR3 wrapper. Word hits are acked one
//               cycle after the request; misses optionally write the dirty
//               victim back (byte mask = dirty bytes only), then fill the
//               line, after which the still-pending request hits.
// Ports       : clk, rst (synchronous, active-low)
//               ws_*  CPU-side Wishbone slave (addr/din/sel/cyc/stb/we in,
//                     ack/dout out)
//               wm_*  DDR-side Wishbone master (addr/din/dm/cyc/stb/we out,
//                     ack/dout in)
//               hit_cnt/miss_cnt  only when DDR_LINE_CACHE_STATS_EN is defined
// Options     : DDR_LINE_CACHE_STATS_EN - adds 32-bit hit and miss counters
// Revision    : 1.0 - initial release
// ============================================================================
module ddr_line_cache
    import ddr_cache_pkg::*;
#(
    parameter int IDX_W  = 2,
    parameter int ADDR_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_W-1:0]     ws_addr,
    input  logic [31:0]           ws_din,
    input  logic [3:0]            ws_sel,
    input  logic                  ws_cyc,
    input  logic                  ws_stb,
    input  logic                  ws_we,
    output logic                  ws_ack,
    output logic [31:0]           ws_dout,
    output logic [ADDR_W-1:0]     wm_addr,
    output logic [LINE_BITS-1:0]  wm_din,
    output logic [LINE_BYTES-1:0] wm_dm,
    output logic                  wm_cyc,
    output logic                  wm_stb,
    output logic                  wm_we,
    input  logic                  wm_ack,
    input  logic [LINE_BITS-1:0]  wm_dout
`ifdef DDR_LINE_CACHE_STATS_EN
    ,
    output logic [31:0]           hit_cnt,
    output logic [31:0]           miss_cnt
`endif
);

    localparam int NUM_LINES = 2 ** IDX_W;
    localparam int TAG_W     = ADDR_W - OFFSET_W - IDX_W;
    localparam int LADDR_W   = ADDR_W - OFFSET_W;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e                  state_q, state_d;
    logic [NUM_LINES-1:0]    valid_q, valid_d;
    logic [TAG_W-1:0]        tag_q   [NUM_LINES];
    logic [TAG_W-1:0]        tag_d   [NUM_LINES];
    logic [LINE_BITS-1:0]    data_q  [NUM_LINES];
    logic [LINE_BITS-1:0]    data_d  [NUM_LINES];
    logic [LINE_BYTES-1:0]   dirty_q [NUM_LINES];
    logic [LINE_BYTES-1:0]   dirty_d [NUM_LINES];
    // Tag+index of the miss being serviced, so the fill lands correctly
    // even if the CPU changes or drops its request meanwhile.
    logic [LADDR_W-1:0]      req_line_q, req_line_d;

    logic                    ws_ack_q, ws_ack_d;
    logic [31:0]             ws_dout_q, ws_dout_d;
    logic [ADDR_W-1:0]       wm_addr_q, wm_addr_d;
    logic [LINE_BITS-1:0]    wm_din_q, wm_din_d;
    logic [LINE_BYTES-1:0]   wm_dm_q, wm_dm_d;
    logic                    wm_we_q, wm_we_d;
    logic                    wm_cyc_q, wm_cyc_d;

`ifdef DDR_LINE_CACHE_STATS_EN
    logic [31:0]             hit_cnt_q, hit_cnt_d;
    logic [31:0]             miss_cnt_q, miss_cnt_d;
`endif

    // ------------------------------------------------------------------
    // Address decode and lookup
    // ------------------------------------------------------------------
    logic [TAG_W-1:0]        w_tag;
    logic [IDX_W-1:0]        w_idx;
    logic [WORD_SEL_W-1:0]   w_word;
    logic                    w_req;
    logic                    w_hit;
    logic                    w_victim_dirty;
    logic [IDX_W-1:0]        w_req_idx;
    logic [TAG_W-1:0]        w_req_tag;
    logic [LINE_BITS-1:0]    w_merge_line;
    logic [LINE_BYTES-1:0]   w_merge_dirty;
    logic                    w_unused_ok;

    assign w_tag          = ws_addr[ADDR_W-1 -: TAG_W];
    assign w_idx          = ws_addr[OFFSET_W +: IDX_W];
    assign w_word         = ws_addr[2 +: WORD_SEL_W];
    assign w_req          = ws_cyc & ws_stb;
    assign w_hit          = valid_q[w_idx] && (tag_q[w_idx] == w_tag);
    assign w_victim_dirty = valid_q[w_idx] && (|dirty_q[w_idx]);
    assign w_req_idx      = req_line_q[IDX_W-1:0];
    assign w_req_tag      = req_line_q[LADDR_W-1 -: TAG_W];
    // Byte-within-word address bits are implied by ws_sel.
    assign w_unused_ok    = &{1'b0, ws_addr[1:0]};

    ddr_cache_line_merge u_merge (
        .line_i  (data_q[w_idx]),
        .dirty_i (dirty_q[w_idx]),
        .word_i  (w_word),
        .din_i   (ws_din),
        .sel_i   (ws_sel),
        .line_o  (w_merge_line),
        .dirty_o (w_merge_dirty)
    );

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        valid_d    = valid_q;
        tag_d      = tag_q;
        data_d     = data_q;
        dirty_d    = dirty_q;
        req_line_d = req_line_q;
        ws_ack_d   = 1'b0;
        ws_dout_d  = ws_dout_q;
        wm_addr_d  = wm_addr_q;
        wm_din_d   = wm_din_q;
        wm_dm_d    = wm_dm_q;
        wm_we_d    = wm_we_q;
        wm_cyc_d   = wm_cyc_q;
`ifdef DDR_LINE_CACHE_STATS_EN
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
`endif

        case (state_q)
            IDLE: begin
                if (w_req) begin
                    if (w_hit) begin
                        if (ws_we) begin
                            data_d[w_idx]  = w_merge_line;
                            dirty_d[w_idx] = w_merge_dirty;
                        end else begin
                            ws_dout_d = data_q[w_idx][{w_word, 5'b00000} +: 32];
                        end
                        ws_ack_d = 1'b1;
                        state_d  = ACK;
`ifdef DDR_LINE_CACHE_STATS_EN
                        hit_cnt_d = hit_cnt_q + 32'd1;
`endif
                    end else begin
                        req_line_d = ws_addr[ADDR_W-1:OFFSET_W];
                        wm_cyc_d   = 1'b1;
                        if (w_victim_dirty) begin
                            wm_addr_d = {tag_q[w_idx], w_idx, {OFFSET_W{1'b0}}};
                            wm_din_d  = data_q[w_idx];
                            wm_dm_d   = dirty_q[w_idx];
                            wm_we_d   = 1'b1;
                            state_d   = WB;
                        end else begin
                            wm_addr_d = {ws_addr[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
                            wm_we_d   = 1'b0;
                            state_d   = FILL;
                        end
`ifdef DDR_LINE_CACHE_STATS_EN
                        miss_cnt_d = miss_cnt_q + 32'd1;
`endif
                    end
                end
            end

            // Turnaround: a request still held on stb is not re-served here.
            ACK: begin
                state_d = IDLE;
            end

            // wm_cyc stays asserted straight into the fill request.
            WB: begin
                if (wm_ack) begin
                    dirty_d[w_req_idx] = '0;
                    wm_we_d            = 1'b0;
                    wm_addr_d          = {req_line_q, {OFFSET_W{1'b0}}};
                    state_d            = FILL;
                end
            end

            FILL: begin
                if (wm_ack) begin
                    data_d[w_req_idx]  = wm_dout;
                    tag_d[w_req_idx]   = w_req_tag;
                    valid_d[w_req_idx] = 1'b1;
                    dirty_d[w_req_idx] = '0;
                    wm_cyc_d           = 1'b0;
                    state_d            = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers. Line data and tags are qualified by valid, so
    // they hold through reset rather than being cleared.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            valid_q    <= '0;
            for (int i = 0; i < NUM_LINES; i++) begin
                dirty_q[i] <= '0;
            end
            req_line_q <= '0;
            ws_ack_q   <= 1'b0;
            ws_dout_q  <= '0;
            wm_addr_q  <= '0;
            wm_din_q   <= '0;
            wm_dm_q    <= '0;
            wm_we_q    <= 1'b0;
            wm_cyc_q   <= 1'b0;
`ifdef DDR_LINE_CACHE_STATS_EN
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            valid_q    <= valid_d;
            tag_q      <= tag_d;
            data_q     <= data_d;
            dirty_q    <= dirty_d;
            req_line_q <= req_line_d;
            ws_ack_q   <= ws_ack_d;
            ws_dout_q  <= ws_dout_d;
            wm_addr_q  <= wm_addr_d;
            wm_din_q   <= wm_din_d;
            wm_dm_q    <= wm_dm_d;
            wm_we_q    <= wm_we_d;
            wm_cyc_q   <= wm_cyc_d;
`ifdef DDR_LINE_CACHE_STATS_EN
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
`endif
        end
    end

    assign ws_ack  = ws_ack_q;
    assign ws_dout = ws_dout_q;
    assign wm_addr = wm_addr_q;
    assign wm_din  = wm_din_q;
    assign wm_dm   = wm_dm_q;
    assign wm_we   = wm_we_q;
    assign wm_cyc  = wm_cyc_q;
    assign wm_stb  = wm_cyc_q;

`ifdef DDR_LINE_CACHE_STATS_EN
    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`endif

endmodule : ddr_line_cache
`default_nettype wire

// File: tb/tb_ddr_line_cache.sv
`default_nettype none
// ============================================================================
// Module      : tb_ddr_line_cache
// Description : Self-checking bench for ddr_line_cache. A behavioural DDR
//               line memory answers downstream requests after a fixed delay
//               and logs each request; expected CPU read data is queued when
//               a read is issued and compared when ws_ack arrives.
//               Define DDR_LINE_CACHE_STATS_EN to also check the counters.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ddr_line_cache;

    localparam int DDR_LAT = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  ws_addr;
    logic [31:0]  ws_din;
    logic [3:0]   ws_sel;
    logic         ws_cyc, ws_stb, ws_we;
    logic         ws_ack;
    logic [31:0]  ws_dout;
    logic [31:0]  wm_addr;
    logic [511:0] wm_din;
    logic [63:0]  wm_dm;
    logic         wm_cyc, wm_stb, wm_we;
    logic         wm_ack;
    logic [511:0] wm_dout;
`ifdef DDR_LINE_CACHE_STATS_EN
    logic [31:0]  hit_cnt, miss_cnt;
`endif

    always #5 clk = ~clk;

    ddr_line_cache #(.IDX_W(2), .ADDR_W(32)) dut (
        .clk     (clk),
        .rst     (rst),
        .ws_addr (ws_addr),
        .ws_din  (ws_din),
        .ws_sel  (ws_sel),
        .ws_cyc  (ws_cyc),
        .ws_stb  (ws_stb),
        .ws_we   (ws_we),
        .ws_ack  (ws_ack),
        .ws_dout (ws_dout),
        .wm_addr (wm_addr),
        .wm_din  (wm_din),
        .wm_dm   (wm_dm),
        .wm_cyc  (wm_cyc),
        .wm_stb  (wm_stb),
        .wm_we   (wm_we),
        .wm_ack  (wm_ack),
        .wm_dout (wm_dout)
`ifdef DDR_LINE_CACHE_STATS_EN
        ,
        .hit_cnt (hit_cnt),
        .miss_cnt(miss_cnt)
`endif
    );

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [63:0] dm;
        logic [31:0] w1;
    } req_t;

    req_t         req_log[$];
    logic [31:0]  exp_q[$];
    logic [511:0] mem [logic [31:0]];
    int           ddr_cnt = 0;
    bit           ddr_en  = 1'b1;
    int           n_vec   = 0;
    int           n_err   = 0;

    function automatic logic [511:0] rd_line(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return '0;
    endfunction

    // DDR model: one step per cycle, called #1 after each rising edge.
    task automatic ddr_step();
        req_t         r;
        logic [511:0] line;
        if (!ddr_en) return;
        if (wm_ack) begin
            wm_ack = 1'b0;
        end else if (wm_cyc) begin
            if (ddr_cnt == 0) begin
                r.addr = wm_addr; r.we = wm_we; r.dm = wm_dm; r.w1 = wm_din[63:32];
                req_log.push_back(r);
            end
            ddr_cnt++;
            if (ddr_cnt == DDR_LAT) begin
                ddr_cnt = 0;
                wm_ack  = 1'b1;
                if (wm_we) begin
                    line = rd_line(wm_addr);
                    for (int b = 0; b < 64; b++)
                        if (wm_dm[b]) line[8*b +: 8] = wm_din[8*b +: 8];
                    mem[wm_addr] = line;
                end else begin
                    wm_dout = rd_line(wm_addr);
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        ddr_step();
    endtask

    // One CPU access; returns cycles from request to ws_ack.
    task automatic cpu_access(input logic [31:0] a, input logic we, input logic [31:0] d,
                              input logic [3:0] s, input logic [31:0] exp_rd, output int lat);
        bit          done = 1'b0;
        logic [31:0] e;
        ws_addr = a; ws_we = we; ws_din = d; ws_sel = s;
        ws_cyc  = 1'b1; ws_stb = 1'b1;
        if (!we) exp_q.push_back(exp_rd);
        lat = 0;
        while (!done && lat < 100) begin
            tick();
            lat++;
            if (ws_ack) begin
                done = 1'b1;
                ws_cyc = 1'b0; ws_stb = 1'b0; ws_we = 1'b0;
                if (!we) begin
                    e = exp_q.pop_front();
                    n_vec++;
                    if (ws_dout !== e) begin
                        n_err++;
                        $display("FAIL rd_data addr=%h got=%h exp=%h", a, ws_dout, e);
                    end
                end
            end
        end
        if (!done) begin
            n_vec++; n_err++;
            $display("FAIL access_timeout addr=%h got=no_ack exp=ack", a);
            ws_cyc = 1'b0; ws_stb = 1'b0; ws_we = 1'b0;
            if (!we) void'(exp_q.pop_back());
        end
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        ws_addr = '0; ws_din = '0; ws_sel = '0; ws_cyc = 1'b0; ws_stb = 1'b0; ws_we = 1'b0;
        wm_ack = 1'b0; wm_dout = '0;
        tick(); tick();
        n_vec++;
        if ({ws_ack, wm_cyc, wm_stb, wm_we} !== 4'b0000) begin
            n_err++; $display("FAIL reset_ctl got=%b exp=0000", {ws_ack, wm_cyc, wm_stb, wm_we});
        end
        n_vec++;
        if (wm_addr !== 32'h0) begin
            n_err++; $display("FAIL reset_wm_addr got=%h exp=0", wm_addr);
        end
        n_vec++;
        if (wm_dm !== 64'h0) begin
            n_err++; $display("FAIL reset_wm_dm got=%h exp=0", wm_dm);
        end
        n_vec++;
        if (ws_dout !== 32'h0 || wm_din !== 512'h0) begin
            n_err++; $display("FAIL reset_data got=%h exp=0", ws_dout);
        end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_fill_read();
        int n0 = req_log.size();
        int lat;
        cpu_access(32'h44, 1'b0, 32'h0, 4'h0, 32'hDEADBEEF, lat);
        n_vec++;
        if (req_log.size() != n0 + 1) begin
            n_err++; $display("FAIL fill_req_count got=%0d exp=%0d", req_log.size() - n0, 1);
        end else begin
            n_vec++;
            if (req_log[n0].addr !== 32'h40 || req_log[n0].we !== 1'b0) begin
                n_err++;
                $display("FAIL fill_req got=%h/%b exp=00000040/0", req_log[n0].addr, req_log[n0].we);
            end
        end
        cpu_access(32'h44, 1'b0, 32'h0, 4'h0, 32'hDEADBEEF, lat);
        n_vec++;
        if (lat != 1) begin
            n_err++; $display("FAIL hit_latency got=%0d exp=1", lat);
        end
        cpu_access(32'h40, 1'b0, 32'h0, 4'h0, 32'h11110000, lat);
    endtask

    task automatic test_write_hit();
        int n0 = req_log.size();
        int lat;
        cpu_access(32'h44, 1'b1, 32'h12345678, 4'b0011, 32'h0, lat);
        n_vec++;
        if (lat != 1) begin
            n_err++; $display("FAIL wr_hit_latency got=%0d exp=1", lat);
        end
        cpu_access(32'h44, 1'b0, 32'h0, 4'h0, 32'hDEAD5678, lat);
        // sel=0 write: acknowledged, nothing changes
        cpu_access(32'h48, 1'b1, 32'hFFFFFFFF, 4'b0000, 32'h0, lat);
        cpu_access(32'h48, 1'b0, 32'h0, 4'h0, 32'h22222222, lat);
        n_vec++;
        if (req_log.size() != n0) begin
            n_err++; $display("FAIL wr_hit_traffic got=%0d exp=0", req_log.size() - n0);
        end
    endtask

    task automatic test_writeback();
        int n0 = req_log.size();
        int lat;
        cpu_access(32'h140, 1'b0, 32'h0, 4'h0, 32'hCAFEF00D, lat);
        n_vec++;
        if (req_log.size() != n0 + 2) begin
            n_err++; $display("FAIL wb_req_count got=%0d exp=2", req_log.size() - n0);
        end else begin
            n_vec++;
            if (req_log[n0].addr !== 32'h40 || req_log[n0].we !== 1'b1) begin
                n_err++;
                $display("FAIL wb_req got=%h/%b exp=00000040/1", req_log[n0].addr, req_log[n0].we);
            end
            n_vec++;
            if (req_log[n0].dm !== 64'h30) begin
                n_err++; $display("FAIL wb_dm got=%h exp=%h", req_log[n0].dm, 64'h30);
            end
            n_vec++;
            if (req_log[n0].w1 !== 32'hDEAD5678) begin
                n_err++; $display("FAIL wb_din_w1 got=%h exp=deadbeef->dead5678", req_log[n0].w1);
            end
            n_vec++;
            if (req_log[n0+1].addr !== 32'h140 || req_log[n0+1].we !== 1'b0) begin
                n_err++;
                $display("FAIL wb_fill_req got=%h/%b exp=00000140/0", req_log[n0+1].addr, req_log[n0+1].we);
            end
        end
        // Written-back data must come back from DDR; victim is now clean.
        n0 = req_log.size();
        cpu_access(32'h44, 1'b0, 32'h0, 4'h0, 32'hDEAD5678, lat);
        n_vec++;
        if (req_log.size() != n0 + 1) begin
            n_err++; $display("FAIL clean_victim_count got=%0d exp=1", req_log.size() - n0);
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0] pat = '0;
        int         acks = 0;
        logic [31:0] e;
        ws_addr = 32'h40; ws_we = 1'b0; ws_sel = 4'hF; ws_cyc = 1'b1; ws_stb = 1'b1;
        for (int i = 0; i < 3; i++) exp_q.push_back(32'h11110000);
        for (int c = 0; c < 6; c++) begin
            tick();
            pat[c] = ws_ack;
            if (ws_ack) begin
                acks++;
                e = exp_q.pop_front();
                n_vec++;
                if (ws_dout !== e) begin
                    n_err++; $display("FAIL b2b_data got=%h exp=%h", ws_dout, e);
                end
                if (acks == 3) begin ws_cyc = 1'b0; ws_stb = 1'b0; end
            end
        end
        ws_cyc = 1'b0; ws_stb = 1'b0;
        while (exp_q.size() > 0) void'(exp_q.pop_front());
        n_vec++;
        if (pat !== 6'b010101) begin
            n_err++; $display("FAIL b2b_ack_pattern got=%b exp=%b", pat, 6'b010101);
        end
        tick();
    endtask

    task automatic test_reset_mid_fill();
        bit seen = 1'b0;
        int acks = 0;
        int n0;
        int lat;
        ddr_en = 1'b0;
        ws_addr = 32'h80; ws_we = 1'b0; ws_sel = 4'hF; ws_cyc = 1'b1; ws_stb = 1'b1;
        for (int c = 0; c < 10 && !seen; c++) begin
            tick();
            if (wm_cyc) seen = 1'b1;
        end
        n_vec++;
        if (!seen || wm_addr !== 32'h80) begin
            n_err++; $display("FAIL mid_fill_req got=%b/%h exp=1/00000080", seen, wm_addr);
        end
        ws_cyc = 1'b0; ws_stb = 1'b0;
        rst = 1'b0;
        tick();
        n_vec++;
        if (wm_cyc !== 1'b0) begin
            n_err++; $display("FAIL mid_fill_rst_cyc got=%b exp=0", wm_cyc);
        end
        rst = 1'b1;
        wm_ack = 1'b1; wm_dout = {16{32'h5A5A5A5A}};
        tick();
        if (ws_ack) acks++;
        wm_ack = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (ws_ack || wm_cyc) acks++;
        end
        n_vec++;
        if (acks != 0) begin
            n_err++; $display("FAIL late_ack_ignored got=%0d exp=0", acks);
        end
        ddr_en = 1'b1; ddr_cnt = 0;
        n0 = req_log.size();
        cpu_access(32'h80, 1'b0, 32'h0, 4'h0, 32'h80808080, lat);
        n_vec++;
        if (req_log.size() != n0 + 1 || req_log[req_log.size()-1].addr !== 32'h80) begin
            n_err++; $display("FAIL post_rst_miss got=%0d exp=1", req_log.size() - n0);
        end
    endtask

`ifdef DDR_LINE_CACHE_STATS_EN
    task automatic test_stats();
        logic [31:0] h0 = hit_cnt;
        logic [31:0] m0 = miss_cnt;
        int lat;
        cpu_access(32'h1C4, 1'b0, 32'h0, 4'h0, 32'h77778888, lat);
        for (int i = 0; i < 3; i++) cpu_access(32'h1C4, 1'b0, 32'h0, 4'h0, 32'h77778888, lat);
        n_vec++;
        if (miss_cnt - m0 !== 32'd1) begin
            n_err++; $display("FAIL stats_miss got=%0d exp=1", miss_cnt - m0);
        end
        n_vec++;
        if (hit_cnt - h0 !== 32'd4) begin
            n_err++; $display("FAIL stats_hit got=%0d exp=4", hit_cnt - h0);
        end
    endtask
`endif

    initial begin
        logic [511:0] l;
        l = '0; l[31:0] = 32'h11110000; l[63:32] = 32'hDEADBEEF; l[95:64] = 32'h22222222;
        mem[32'h40]  = l;
        l = '0; l[31:0] = 32'hCAFEF00D;
        mem[32'h140] = l;
        l = '0; l[31:0] = 32'h80808080;
        mem[32'h80]  = l;
        l = '0; l[63:32] = 32'h77778888;
        mem[32'h1C0] = l;

        test_reset();
        test_fill_read();
        test_write_hit();
        test_writeback();
        test_back_to_back();
        test_reset_mid_fill();
`ifdef DDR_LINE_CACHE_STATS_EN
        test_stats();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_ddr_line_cache
`default_nettype wire
